// File: rtl/id_ex_pkg.sv
// id_ex_pkg
// Shared definitions for the ID->EX pipeline stage:
//   - default field widths of the decode-to-execute payload
//   - payload_w(): total payload width for a given set of field widths
//   - id_ex_payload_t: packed payload at the default widths
//   - *_CTRL_NOP: all-zero control groups (a NOP / bubble)
package id_ex_pkg;

  localparam int DATA_W_DEF     = 64;
  localparam int REG_A_W_DEF    = 5;
  localparam int EX_CTRL_W_DEF  = 6;
  localparam int MEM_CTRL_W_DEF = 4;
  localparam int WB_CTRL_W_DEF  = 2;
  localparam int IMM_W_DEF      = 12;

  function automatic int payload_w(input int data_w, input int reg_a_w,
                                   input int ex_w, input int mem_w,
                                   input int wb_w, input int imm_w);
    return 2 * data_w + 2 * reg_a_w + ex_w + mem_w + wb_w + imm_w;
  endfunction

  // 162 bits at the default widths
  localparam int PAYLOAD_W = payload_w(DATA_W_DEF, REG_A_W_DEF, EX_CTRL_W_DEF,
                                       MEM_CTRL_W_DEF, WB_CTRL_W_DEF, IMM_W_DEF);

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     r1;
    logic [DATA_W_DEF-1:0]     r2;
    logic [REG_A_W_DEF-1:0]    wreg;
    logic [REG_A_W_DEF-1:0]    rs2;
    logic [EX_CTRL_W_DEF-1:0]  ex_ctrl;
    logic [MEM_CTRL_W_DEF-1:0] mem_ctrl;
    logic [WB_CTRL_W_DEF-1:0]  wb_ctrl;
    logic [IMM_W_DEF-1:0]      imm;
  } id_ex_payload_t;

  localparam logic [EX_CTRL_W_DEF-1:0]  EX_CTRL_NOP  = '0;
  localparam logic [MEM_CTRL_W_DEF-1:0] MEM_CTRL_NOP = '0;
  localparam logic [WB_CTRL_W_DEF-1:0]  WB_CTRL_NOP  = '0;

endpackage

// File: rtl/id_ex_pipe_stage_skid.sv
// pipe_skid_reg
// Generic WIDTH-bit valid/ready pipeline register with a one-entry skid
// buffer. in_ready_o comes straight from a flop (!skid_valid). Entries leave
// in strict FIFO order (skid entry before any new input).
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   in_valid_i/in_ready_o    upstream handshake, in_data_i payload
//   stall_i                  blocks draining (behaves like out_ready_i=0)
//   flush_i                  kills both entries; bits in CLR_MASK of the main
//                            register are zeroed, the rest hold
//   out_valid_o/out_ready_i  downstream handshake, out_data_o payload
module pipe_skid_reg #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] CLR_MASK = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             acc, drn;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  assign acc = in_valid_i & ~skid_valid_q;
  assign drn = main_valid_q & out_ready_i & ~stall_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      // flush wins over stall, drain and a same-cycle accept
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = main_data_q & ~CLR_MASK;
    end else if (!main_valid_q || drn) begin
      if (skid_valid_q) begin
        // acc is 0 here since in_ready is low while skid is full
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_data_d  = in_data_i;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage
// ID->EX valid/ready pipeline stage with stall hold, flush-to-bubble and a
// one-entry skid buffer. Packs the decode payload into pipe_skid_reg and
// gates the control groups to zero whenever no live instruction is held,
// so a consumer ignoring out_valid_o still sees a NOP.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   in_valid_i/in_ready_o           decode handshake
//   in_r1_i, in_r2_i                operands (DATA_W)
//   in_wreg_i, in_rs2_i             dest / rs2 address (REG_A_W)
//   in_ex/mem/wb_ctrl_i, in_imm_i   control groups and immediate
//   stall_i, flush_i                hazard hold / kill
//   out_valid_o/out_ready_i         execute handshake
//   out_*_o                         registered payload (ctrl gated)
module id_ex_pipe_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_A_W    = REG_A_W_DEF,
  parameter int EX_CTRL_W  = EX_CTRL_W_DEF,
  parameter int MEM_CTRL_W = MEM_CTRL_W_DEF,
  parameter int WB_CTRL_W  = WB_CTRL_W_DEF,
  parameter int IMM_W      = IMM_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     in_r1_i,
  input  logic [DATA_W-1:0]     in_r2_i,
  input  logic [REG_A_W-1:0]    in_wreg_i,
  input  logic [REG_A_W-1:0]    in_rs2_i,
  input  logic [EX_CTRL_W-1:0]  in_ex_ctrl_i,
  input  logic [MEM_CTRL_W-1:0] in_mem_ctrl_i,
  input  logic [WB_CTRL_W-1:0]  in_wb_ctrl_i,
  input  logic [IMM_W-1:0]      in_imm_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_r1_o,
  output logic [DATA_W-1:0]     out_r2_o,
  output logic [REG_A_W-1:0]    out_wreg_o,
  output logic [REG_A_W-1:0]    out_rs2_o,
  output logic [EX_CTRL_W-1:0]  out_ex_ctrl_o,
  output logic [MEM_CTRL_W-1:0] out_mem_ctrl_o,
  output logic [WB_CTRL_W-1:0]  out_wb_ctrl_o,
  output logic [IMM_W-1:0]      out_imm_o
);

  localparam int PW = payload_w(DATA_W, REG_A_W, EX_CTRL_W, MEM_CTRL_W, WB_CTRL_W, IMM_W);

  typedef struct packed {
    logic [DATA_W-1:0]     r1;
    logic [DATA_W-1:0]     r2;
    logic [REG_A_W-1:0]    wreg;
    logic [REG_A_W-1:0]    rs2;
    logic [EX_CTRL_W-1:0]  ex_ctrl;
    logic [MEM_CTRL_W-1:0] mem_ctrl;
    logic [WB_CTRL_W-1:0]  wb_ctrl;
    logic [IMM_W-1:0]      imm;
  } payload_t;

  // only the control groups are scrubbed on flush; data may hold
  localparam payload_t CLR_FIELDS = '{
    r1: '0, r2: '0, wreg: '0, rs2: '0,
    ex_ctrl: '1, mem_ctrl: '1, wb_ctrl: '1, imm: '0
  };

  payload_t in_pl, out_pl;
  logic     main_valid;

  assign in_pl = '{
    r1: in_r1_i, r2: in_r2_i, wreg: in_wreg_i, rs2: in_rs2_i,
    ex_ctrl: in_ex_ctrl_i, mem_ctrl: in_mem_ctrl_i, wb_ctrl: in_wb_ctrl_i,
    imm: in_imm_i
  };

  pipe_skid_reg #(
    .WIDTH    (PW),
    .CLR_MASK (CLR_FIELDS)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_pl),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .out_valid_o (main_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_pl)
  );

  assign out_valid_o    = main_valid;
  assign out_r1_o       = out_pl.r1;
  assign out_r2_o       = out_pl.r2;
  assign out_wreg_o     = out_pl.wreg;
  assign out_rs2_o      = out_pl.rs2;
  assign out_imm_o      = out_pl.imm;
  assign out_ex_ctrl_o  = main_valid ? out_pl.ex_ctrl  : '0;
  assign out_mem_ctrl_o = main_valid ? out_pl.mem_ctrl : '0;
  assign out_wb_ctrl_o  = main_valid ? out_pl.wb_ctrl  : '0;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
module tb_id_ex_pipe_stage;
  import id_ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-width instance
  logic        in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [63:0] in_r1, in_r2, out_r1, out_r2;
  logic [4:0]  in_wreg, in_rs2, out_wreg, out_rs2;
  logic [5:0]  in_ex, out_ex;
  logic [3:0]  in_mem, out_mem;
  logic [1:0]  in_wb, out_wb;
  logic [11:0] in_imm, out_imm;

  id_ex_pipe_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_r1_i(in_r1), .in_r2_i(in_r2), .in_wreg_i(in_wreg), .in_rs2_i(in_rs2),
    .in_ex_ctrl_i(in_ex), .in_mem_ctrl_i(in_mem), .in_wb_ctrl_i(in_wb),
    .in_imm_i(in_imm), .stall_i(stall), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_r1_o(out_r1), .out_r2_o(out_r2), .out_wreg_o(out_wreg),
    .out_rs2_o(out_rs2), .out_ex_ctrl_o(out_ex), .out_mem_ctrl_o(out_mem),
    .out_wb_ctrl_o(out_wb), .out_imm_o(out_imm)
  );

  // DATA_W=32, IMM_W=20 instance
  logic        b_in_valid, b_in_ready, b_out_valid;
  logic [31:0] b_in_r1, b_in_r2, b_out_r1, b_out_r2;
  logic [4:0]  b_in_wreg, b_in_rs2, b_out_wreg, b_out_rs2;
  logic [5:0]  b_in_ex, b_out_ex;
  logic [3:0]  b_in_mem, b_out_mem;
  logic [1:0]  b_in_wb, b_out_wb;
  logic [19:0] b_in_imm, b_out_imm;

  id_ex_pipe_stage #(.DATA_W(32), .IMM_W(20)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_r1_i(b_in_r1), .in_r2_i(b_in_r2), .in_wreg_i(b_in_wreg), .in_rs2_i(b_in_rs2),
    .in_ex_ctrl_i(b_in_ex), .in_mem_ctrl_i(b_in_mem), .in_wb_ctrl_i(b_in_wb),
    .in_imm_i(b_in_imm), .stall_i(1'b0), .flush_i(1'b0),
    .out_valid_o(b_out_valid), .out_ready_i(1'b1),
    .out_r1_o(b_out_r1), .out_r2_o(b_out_r2), .out_wreg_o(b_out_wreg),
    .out_rs2_o(b_out_rs2), .out_ex_ctrl_o(b_out_ex), .out_mem_ctrl_o(b_out_mem),
    .out_wb_ctrl_o(b_out_wb), .out_imm_o(b_out_imm)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: the stage is a two-deep FIFO of instructions
  id_ex_payload_t q[$];

  function automatic id_ex_payload_t rnd_pl();
    id_ex_payload_t p;
    p.r1       = {$urandom, $urandom};
    p.r2       = {$urandom, $urandom};
    p.wreg     = 5'($urandom);
    p.rs2      = 5'($urandom);
    p.ex_ctrl  = 6'($urandom);
    p.mem_ctrl = 4'($urandom);
    p.wb_ctrl  = 2'($urandom_range(1, 3));
    p.imm      = 12'($urandom);
    return p;
  endfunction

  task automatic drive(input logic v, input id_ex_payload_t p,
                       input logic st, input logic fl, input logic ordy);
    in_valid  = v;
    in_r1     = p.r1;
    in_r2     = p.r2;
    in_wreg   = p.wreg;
    in_rs2    = p.rs2;
    in_ex     = p.ex_ctrl;
    in_mem    = p.mem_ctrl;
    in_wb     = p.wb_ctrl;
    in_imm    = p.imm;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic check_outputs();
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("r1", out_r1, q[0].r1);
      chk("r2", out_r2, q[0].r2);
      chk("wreg", 64'(out_wreg), 64'(q[0].wreg));
      chk("rs2", 64'(out_rs2), 64'(q[0].rs2));
      chk("ex_ctrl", 64'(out_ex), 64'(q[0].ex_ctrl));
      chk("mem_ctrl", 64'(out_mem), 64'(q[0].mem_ctrl));
      chk("wb_ctrl", 64'(out_wb), 64'(q[0].wb_ctrl));
      chk("imm", 64'(out_imm), 64'(q[0].imm));
    end else begin
      chk("bubble_ex", 64'(out_ex), 64'(EX_CTRL_NOP));
      chk("bubble_mem", 64'(out_mem), 64'(MEM_CTRL_NOP));
      chk("bubble_wb", 64'(out_wb), 64'(WB_CTRL_NOP));
    end
  endtask

  // one clock: update the model from the driven inputs, then check
  task automatic step();
    bit acc, drn;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready && !stall;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{r1: in_r1, r2: in_r2, wreg: in_wreg, rs2: in_rs2,
                             ex_ctrl: in_ex, mem_ctrl: in_mem, wb_ctrl: in_wb,
                             imm: in_imm});
    end
    @(negedge clk);
    check_outputs();
  endtask

  id_ex_payload_t p;
  bit seen_killed;

  initial begin
    p = rnd_pl();
    drive(1'b0, p, 1'b0, 1'b0, 1'b1);
    b_in_valid = 1'b0; b_in_r1 = '0; b_in_r2 = '0; b_in_wreg = '0; b_in_rs2 = '0;
    b_in_ex = '0; b_in_mem = '0; b_in_wb = '0; b_in_imm = '0;

    // reset state
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_r1", out_r1, 64'd0);
    chk("rst_wb", 64'(out_wb), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // 1: streaming
    for (int i = 0; i < 3; i++) begin
      p = rnd_pl(); p.wreg = 5'(i + 1); p.r1 = 64'hA + 64'(i);
      drive(1'b1, p, 1'b0, 1'b0, 1'b1);
      step();
      chk("stream_wreg", 64'(out_wreg), 64'(i + 1));
      chk("stream_r1", out_r1, 64'hA + 64'(i));
    end
    drive(1'b0, p, 1'b0, 1'b0, 1'b1);
    step(); step();

    // 2: backpressure
    p = rnd_pl(); p.wreg = 5'd4; drive(1'b1, p, 1'b0, 1'b0, 1'b0); step();
    p = rnd_pl(); p.wreg = 5'd5; drive(1'b1, p, 1'b0, 1'b0, 1'b0); step();
    chk("bp_hold_wreg", 64'(out_wreg), 64'd4);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, rnd_pl(), 1'b0, 1'b0, 1'b0); step();  // refused
    drive(1'b0, p, 1'b0, 1'b0, 1'b1); step();
    chk("bp_second_wreg", 64'(out_wreg), 64'd5);
    step(); step();

    // 3: stall
    p = rnd_pl(); p.imm = 12'h7FF; drive(1'b1, p, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, p, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_imm", 64'(out_imm), 64'h7FF);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
    end
    drive(1'b0, p, 1'b0, 1'b0, 1'b1); step();
    chk("stall_release", {63'd0, out_valid}, 64'd0);

    // 4: flush with full skid and a pending input
    p = rnd_pl(); p.wreg = 5'd6; drive(1'b1, p, 1'b0, 1'b0, 1'b0); step();
    p = rnd_pl(); p.wreg = 5'd7; drive(1'b1, p, 1'b0, 1'b0, 1'b0); step();
    p = rnd_pl(); p.wreg = 5'd8; drive(1'b1, p, 1'b1, 1'b1, 1'b1); step();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_wb", 64'(out_wb), 64'd0);
    chk("flush_mem", 64'(out_mem), 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen_killed = 1'b0;
    drive(1'b0, p, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid && out_wreg inside {5'd6, 5'd7, 5'd8}) seen_killed = 1'b1;
    end
    chk("flush_no_resurrect", {63'd0, seen_killed}, 64'd0);

    // 5: async reset mid-stream
    p = rnd_pl(); drive(1'b1, p, 1'b0, 1'b0, 1'b0); step();
    p = rnd_pl(); drive(1'b1, p, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, p, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_r1", out_r1, 64'd0);
    chk("arst_r2", out_r2, 64'd0);
    chk("arst_wreg", 64'(out_wreg), 64'd0);
    chk("arst_ex", 64'(out_ex), 64'd0);
    chk("arst_imm", 64'(out_imm), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 9) < 7), rnd_pl(),
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 5),
            1'($urandom_range(0, 9) < 6));
      step();
    end
    drive(1'b0, p, 1'b0, 1'b0, 1'b1);
    step(); step(); step();

    // 6: narrow-data / wide-imm instance, streaming
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1;
      b_in_wreg  = 5'(i + 1);
      b_in_r1    = 32'hA + 32'(i);
      b_in_r2    = 32'hDEADBEEF;
      b_in_imm   = 20'hFFFFF;
      b_in_wb    = 2'd1;
      @(negedge clk);
      chk("p_valid", {63'd0, b_out_valid}, 64'd1);
      chk("p_in_ready", {63'd0, b_in_ready}, 64'd1);
      chk("p_wreg", 64'(b_out_wreg), 64'(i + 1));
      chk("p_r1", 64'(b_out_r1), 64'hA + 64'(i));
      chk("p_r2", 64'(b_out_r2), 64'hDEADBEEF);
      chk("p_imm", 64'(b_out_imm), 64'hFFFFF);
    end
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("p_drained", {63'd0, b_out_valid}, 64'd0);
    chk("p_bubble_wb", 64'(b_out_wb), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
